// File: rtl/i2s_capture_ctrl_if.sv
// i2s_capture_ctrl_if
//   Groups the I2S capture controller's serial, buffer-write and buffer-read
//   signals into one bundle.
//   master : the capture controller. It drives sck/ws, the write port and the grants.
//   slave  : the environment. It drives ena, sd_in and the read requests.
//   With I2S_CAPTURE_FRAME_CNT_EN defined, the bundle also carries frame_count[7:0].
interface i2s_capture_ctrl_if #(
    parameter int NUMBER_OF_BITS = 8
);
    logic                      ena;
    logic                      sd_in;
    logic                      sck_out;
    logic                      ws_out;
    logic                      buf_wr_en;
    logic                      buf_wr_ch;
    logic [3:0]                buf_wr_addr;
    logic [NUMBER_OF_BITS-1:0] buf_wr_data;
    logic [1:0]                rd_req;
    logic [3:0]                rd_ofs0;
    logic [3:0]                rd_ofs1;
    logic [1:0]                rd_gnt;
    logic [3:0]                buf_rd_addr;
`ifdef I2S_CAPTURE_FRAME_CNT_EN
    logic [7:0]                frame_count;
`endif

    modport master (
        input  ena, sd_in, rd_req, rd_ofs0, rd_ofs1,
        output sck_out, ws_out, buf_wr_en, buf_wr_ch, buf_wr_addr, buf_wr_data,
        output rd_gnt, buf_rd_addr
`ifdef I2S_CAPTURE_FRAME_CNT_EN
        , output frame_count
`endif
    );

    modport slave (
        output ena, sd_in, rd_req, rd_ofs0, rd_ofs1,
        input  sck_out, ws_out, buf_wr_en, buf_wr_ch, buf_wr_addr, buf_wr_data,
        input  rd_gnt, buf_rd_addr
`ifdef I2S_CAPTURE_FRAME_CNT_EN
        , input frame_count
`endif
    );
endinterface

// File: rtl/i2s_capture_ctrl.sv
// i2s_capture_ctrl
//   I2S master receiver. The block generates SCK and WS, deserializes sd_in
//   MSB-first with the standard one-bit delay, and writes each channel
//   sample into an external frame buffer. The buffer holds
//   SAMPLES_BUFFER_SIZE frames, and one slot holds one frame.
//   Two readers share the buffer read address through a round-robin
//   arbiter. Each reader addresses a frame by its age relative to the
//   newest completed frame.
// Ports
//   clk, rst_n : clock and asynchronous active-low reset.
//   bus        : i2s_capture_ctrl_if.master. It carries the following signals:
//     - ena and sd_in (inputs).
//     - sck_out and ws_out (outputs).
//     - buf_wr_en, buf_wr_ch, buf_wr_addr and buf_wr_data (outputs).
//     - rd_req, rd_ofs0 and rd_ofs1 (inputs).
//     - rd_gnt and buf_rd_addr (outputs).
// Option
//   I2S_CAPTURE_FRAME_CNT_EN adds bus.frame_count. It is a saturating
//   count of completed frames.
module i2s_capture_ctrl #(
    parameter int NUMBER_OF_BITS      = 8,
    parameter int SAMPLES_BUFFER_SIZE = 10,
    parameter int SCK_DIV             = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    i2s_capture_ctrl_if.master bus
);
    localparam int            CW       = $clog2(NUMBER_OF_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUMBER_OF_BITS - 1);
    localparam logic [3:0]    DIV_LAST = 4'(SCK_DIV - 1);
    localparam logic [3:0]    PTR_LAST = 4'(SAMPLES_BUFFER_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SHIFT, COMMIT} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                div_cnt_q, div_cnt_d;
    logic                      sck_q, sck_d;
    logic                      ws_q, ws_d;
    logic [CW-1:0]             fall_cnt_q, fall_cnt_d;
    logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                      skip_q, skip_d;
    logic                      ch_q, ch_d;
    logic [NUMBER_OF_BITS-1:0] shift_q, shift_d;
    logic [3:0]                wr_ptr_q, wr_ptr_d;
    logic [3:0]                last_ptr_q, last_ptr_d;
    logic                      last_vld_q, last_vld_d;
    logic                      prio_q, prio_d;
    logic [1:0]                gnt_q, gnt_d;
    logic [3:0]                rd_addr_q, rd_addr_d;
`ifdef I2S_CAPTURE_FRAME_CNT_EN
    logic [7:0]                frame_cnt_q, frame_cnt_d;
`endif

    logic tick, sck_rise, sck_fall, ws_wrap;
    logic sel;
    logic [3:0] ofs_raw, ofs_sat;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign sck_rise = tick & ~sck_q;
    assign sck_fall = tick & sck_q;
    // WS flips on the last SCK fall of each NUMBER_OF_BITS-period word.
    assign ws_wrap  = sck_fall && (fall_cnt_q == LAST_BIT);

    // Clock generation and capture FSM
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        sck_d      = sck_q;
        ws_d       = ws_q;
        fall_cnt_d = fall_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        skip_d     = skip_q;
        ch_d       = ch_q;
        shift_d    = shift_q;
        wr_ptr_d   = wr_ptr_q;
        last_ptr_d = last_ptr_q;
        last_vld_d = last_vld_q;
`ifdef I2S_CAPTURE_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
`endif

        if (state_q != IDLE) begin
            div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;
            if (tick) sck_d = ~sck_q;
            if (sck_fall) fall_cnt_d = ws_wrap ? '0 : fall_cnt_q + CW'(1);
            if (ws_wrap) ws_d = ~ws_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.ena) state_d = SYNC;
            end
            SYNC: begin
                if (!bus.ena) begin
                    state_d = IDLE;
                end else if (ws_wrap && ws_q) begin
                    // On the first 1->0 WS edge, the next rise carries the
                    // LSB of a right word that was never captured. Skip it.
                    state_d   = SHIFT;
                    skip_d    = 1'b1;
                    bit_cnt_d = '0;
                    ch_d      = 1'b0;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        shift_d    = shift_q << 1;
                        shift_d[0] = bus.sd_in;
                        bit_cnt_d  = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == LAST_BIT) state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                bit_cnt_d = '0;
                ch_d      = ~ch_q;
                state_d   = SHIFT;
                if (ch_q) begin
                    wr_ptr_d   = (wr_ptr_q == PTR_LAST) ? 4'd0 : wr_ptr_q + 4'd1;
                    last_ptr_d = wr_ptr_q;
                    last_vld_d = 1'b1;
`ifdef I2S_CAPTURE_FRAME_CNT_EN
                    if (frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
`endif
                    // Stopping is only allowed on a frame boundary.
                    if (!bus.ena) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Park the clocks when entering IDLE. This keeps SCK low for the
        // whole IDLE period, and the next SYNC starts from a known phase.
        if (state_d == IDLE) begin
            div_cnt_d  = 4'd0;
            sck_d      = 1'b0;
            ws_d       = 1'b1;
            fall_cnt_d = '0;
        end
    end

    // Round-robin read arbiter. It uses last_ptr_q, so a grant during a
    // right commit addresses the frame from before the update.
    always_comb begin
        gnt_d     = 2'b00;
        prio_d    = prio_q;
        rd_addr_d = rd_addr_q;
        sel       = bus.rd_req[1] & (~bus.rd_req[0] | prio_q);
        ofs_raw   = sel ? bus.rd_ofs1 : bus.rd_ofs0;
        ofs_sat   = (ofs_raw > PTR_LAST) ? PTR_LAST : ofs_raw;
        if (last_vld_q && (|bus.rd_req)) begin
            gnt_d  = sel ? 2'b10 : 2'b01;
            prio_d = ~sel;
            if (last_ptr_q >= ofs_sat)
                rd_addr_d = last_ptr_q - ofs_sat;
            else
                rd_addr_d = 4'({1'b0, last_ptr_q} + 5'(SAMPLES_BUFFER_SIZE) - {1'b0, ofs_sat});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= 4'd0;
            sck_q      <= 1'b0;
            ws_q       <= 1'b1;
            fall_cnt_q <= '0;
            bit_cnt_q  <= '0;
            skip_q     <= 1'b0;
            ch_q       <= 1'b0;
            shift_q    <= '0;
            wr_ptr_q   <= 4'd0;
            last_ptr_q <= 4'd0;
            last_vld_q <= 1'b0;
            prio_q     <= 1'b0;
            gnt_q      <= 2'b00;
            rd_addr_q  <= 4'd0;
`ifdef I2S_CAPTURE_FRAME_CNT_EN
            frame_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            sck_q      <= sck_d;
            ws_q       <= ws_d;
            fall_cnt_q <= fall_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            skip_q     <= skip_d;
            ch_q       <= ch_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            last_ptr_q <= last_ptr_d;
            last_vld_q <= last_vld_d;
            prio_q     <= prio_d;
            gnt_q      <= gnt_d;
            rd_addr_q  <= rd_addr_d;
`ifdef I2S_CAPTURE_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    // The shift register stays still for the whole COMMIT cycle, because
    // SCK rises are at least two clk cycles apart. It can therefore drive
    // the write data directly.
    assign bus.sck_out     = sck_q;
    assign bus.ws_out      = ws_q;
    assign bus.buf_wr_en   = (state_q == COMMIT);
    assign bus.buf_wr_ch   = ch_q;
    assign bus.buf_wr_addr = wr_ptr_q;
    assign bus.buf_wr_data = shift_q;
    assign bus.rd_gnt      = gnt_q;
    assign bus.buf_rd_addr = rd_addr_q;
`ifdef I2S_CAPTURE_FRAME_CNT_EN
    assign bus.frame_count = frame_cnt_q;
`endif
endmodule
